// File: rtl/ms_window_accumulator.sv
// ms_window_accumulator
//
// Samples a 32-bit signed master-slave value every enabled clock, sums
// WINDOW consecutive samples, and queues each finished window sum in a
// DEPTH-entry FIFO that drains through a notify/sync output port.
// Sampling never stalls: if the FIFO is full when a window completes, that
// result is discarded and drop_cnt counts it (saturating at 0xFFFF).
//
// Optional build macro: MS_WINDOW_ACC_SATURATE_EN
//   defined   - accumulation saturates instead of wrapping, and sat_flag
//               reports whether the FIFO head result saturated.
//   undefined - 32-bit wrap arithmetic, no sat_flag port.
//
// Parameters:
//   WINDOW  samples per window (1..255)
//   DEPTH   result FIFO entries (power of two, >= 2)
//
// Ports:
//   clk           clock
//   rst           asynchronous, active-high reset
//   s_in[31:0]    signed sample, taken at posedge while en is high
//   en            sampling enable; dropping it discards a partial window
//   m_out[31:0]   FIFO head window sum (0 when empty)
//   m_out_notify  FIFO head is valid
//   m_out_sync    consumer ready; transfer when notify && sync
//   drop_cnt      windows dropped due to a full FIFO (saturating)
//   sat_flag      (macro only) FIFO head result saturated
//   busy          a window is partially accumulated

`default_nettype none

module ms_window_accumulator #(
  parameter int WINDOW = 4,
  parameter int DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_in,
  input  logic        en,
  output logic [31:0] m_out,
  output logic        m_out_notify,
  input  logic        m_out_sync,
  output logic [15:0] drop_cnt,
`ifdef MS_WINDOW_ACC_SATURATE_EN
  output logic        sat_flag,
`endif
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] WIN_LAST = WINDOW[7:0];
  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  typedef enum logic [0:0] {
    SEC_IDLE = 1'b0,
    SEC_ACC  = 1'b1
  } section_t;

  section_t state, state_next;
  logic [31:0] acc, acc_next;
  logic [7:0]  cnt, cnt_next, cnt_inc;
  logic [31:0] step_sum;
  logic        push;
  logic        complete;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty, full, pop, push_ok, drop;

`ifdef MS_WINDOW_ACC_SATURATE_EN
  logic        sat_acc, sat_acc_next, step_sat;
  logic [32:0] wide_sum;
  logic        flag_mem [DEPTH];
`endif

  // One accumulate step. acc is always zero at the start of a window, so
  // acc + s_in also yields the first sample of a fresh window.
`ifdef MS_WINDOW_ACC_SATURATE_EN
  always_comb begin
    wide_sum = {acc[31], acc} + {s_in[31], s_in};
    step_sat = (wide_sum[32] != wide_sum[31]);
    if (step_sat) begin
      step_sum = wide_sum[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      step_sum = wide_sum[31:0];
    end
  end
`else
  always_comb begin
    step_sum = acc + s_in;
  end
`endif

  assign cnt_inc  = cnt + 8'd1;
  assign complete = en && (cnt_inc == WIN_LAST);

  // Section FSM next-state: the window closes on the cycle its last sample
  // is taken, clearing acc/cnt while staying in SEC_ACC so the next enabled
  // cycle immediately starts a new window.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    push       = 1'b0;
`ifdef MS_WINDOW_ACC_SATURATE_EN
    sat_acc_next = sat_acc;
`endif
    case (state)
      SEC_IDLE, SEC_ACC: begin
        if (en) begin
          state_next = SEC_ACC;
          if (complete) begin
            push     = 1'b1;
            acc_next = 32'd0;
            cnt_next = 8'd0;
`ifdef MS_WINDOW_ACC_SATURATE_EN
            sat_acc_next = 1'b0;
`endif
          end else begin
            acc_next = step_sum;
            cnt_next = cnt_inc;
`ifdef MS_WINDOW_ACC_SATURATE_EN
            sat_acc_next = sat_acc | step_sat;
`endif
          end
        end else begin
          state_next = SEC_IDLE;
          acc_next   = 32'd0;
          cnt_next   = 8'd0;
`ifdef MS_WINDOW_ACC_SATURATE_EN
          sat_acc_next = 1'b0;
`endif
        end
      end
      default: begin
        state_next = SEC_IDLE;
        acc_next   = 32'd0;
        cnt_next   = 8'd0;
      end
    endcase
  end

  // Section FSM and accumulator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SEC_IDLE;
      acc   <= 32'd0;
      cnt   <= 8'd0;
`ifdef MS_WINDOW_ACC_SATURATE_EN
      sat_acc <= 1'b0;
`endif
    end else begin
      state <= state_next;
      acc   <= acc_next;
      cnt   <= cnt_next;
`ifdef MS_WINDOW_ACC_SATURATE_EN
      sat_acc <= sat_acc_next;
`endif
    end
  end

  assign busy = (cnt != 8'd0);

  // FIFO control. A pop in the same cycle frees the slot, so a push into a
  // full FIFO is only dropped when no transfer happens alongside it.
  assign empty        = (count == '0);
  assign full         = (count == FULL_COUNT);
  assign m_out_notify = !empty;
  assign pop          = m_out_notify && m_out_sync;
  assign push_ok      = push && (!full || pop);
  assign drop         = push && full && !pop;

  assign m_out = empty ? 32'd0 : mem[rd_ptr];
`ifdef MS_WINDOW_ACC_SATURATE_EN
  assign sat_flag = !empty && flag_mem[rd_ptr];
`endif

  // FIFO pointers, occupancy and drop accounting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= 16'd0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push_ok && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push_ok) begin
        count <= count - 1'b1;
      end
      if (drop && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // FIFO storage; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= step_sum;
`ifdef MS_WINDOW_ACC_SATURATE_EN
      flag_mem[wr_ptr] <= sat_acc | step_sat;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ms_window_accumulator.sv
// tb_ms_window_accumulator
//
// Directed self-checking bench for ms_window_accumulator. Three instances
// cover the parameter sets used: a (WINDOW=4, DEPTH=4), b (WINDOW=1,
// DEPTH=4) and c (WINDOW=1, DEPTH=2). Inputs change 1 time unit after the
// rising edge and outputs are checked at that same point.

`timescale 1ns/1ps

module tb_ms_window_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [31:0] a_s_in = 32'd0, b_s_in = 32'd0, c_s_in = 32'd0;
  logic a_en = 1'b0, b_en = 1'b0, c_en = 1'b0;
  logic a_sync = 1'b0, b_sync = 1'b0, c_sync = 1'b0;
  logic [31:0] a_m_out, b_m_out, c_m_out;
  logic a_notify, b_notify, c_notify;
  logic [15:0] a_drop, b_drop, c_drop;
  logic a_busy, b_busy, c_busy;
`ifdef MS_WINDOW_ACC_SATURATE_EN
  logic a_sat, b_sat, c_sat;
`endif

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  ms_window_accumulator #(.WINDOW(4), .DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .s_in(a_s_in), .en(a_en), .m_out(a_m_out),
    .m_out_notify(a_notify), .m_out_sync(a_sync), .drop_cnt(a_drop),
`ifdef MS_WINDOW_ACC_SATURATE_EN
    .sat_flag(a_sat),
`endif
    .busy(a_busy)
  );

  ms_window_accumulator #(.WINDOW(1), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .s_in(b_s_in), .en(b_en), .m_out(b_m_out),
    .m_out_notify(b_notify), .m_out_sync(b_sync), .drop_cnt(b_drop),
`ifdef MS_WINDOW_ACC_SATURATE_EN
    .sat_flag(b_sat),
`endif
    .busy(b_busy)
  );

  ms_window_accumulator #(.WINDOW(1), .DEPTH(2)) dut_c (
    .clk(clk), .rst(rst), .s_in(c_s_in), .en(c_en), .m_out(c_m_out),
    .m_out_notify(c_notify), .m_out_sync(c_sync), .drop_cnt(c_drop),
`ifdef MS_WINDOW_ACC_SATURATE_EN
    .sat_flag(c_sat),
`endif
    .busy(c_busy)
  );

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks_total++;
    if (a_notify !== 1'b0) $display("[TB] FAIL reset_notify_a: got %b expected 0", a_notify);
    else checks_passed++;
    checks_total++;
    if (a_m_out !== 32'd0) $display("[TB] FAIL reset_m_out_a: got %h expected 00000000", a_m_out);
    else checks_passed++;
    checks_total++;
    if (a_busy !== 1'b0) $display("[TB] FAIL reset_busy_a: got %b expected 0", a_busy);
    else checks_passed++;
    checks_total++;
    if (a_drop !== 16'd0) $display("[TB] FAIL reset_drop_a: got %0d expected 0", a_drop);
    else checks_passed++;
    checks_total++;
    if ({b_notify, c_notify} !== 2'b00) $display("[TB] FAIL reset_notify_bc: got %b expected 00", {b_notify, c_notify});
    else checks_passed++;
    rst = 1'b0;
    tick();
  endtask

  // Window 1,2,3,4 sums to 10; notify lasts one cycle since sync is held high.
  task automatic test_basic_window();
    a_sync = 1'b1;
    a_en   = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_s_in = 32'(i);
      tick();
      checks_total++;
      if (a_busy !== 1'b1 || a_notify !== 1'b0)
        $display("[TB] FAIL basic_busy_%0d: got busy=%b notify=%b expected busy=1 notify=0", i, a_busy, a_notify);
      else checks_passed++;
    end
    a_s_in = 32'd4;
    tick();
    a_en = 1'b0;
    checks_total++;
    if (a_notify !== 1'b1 || a_m_out !== 32'd10 || a_busy !== 1'b0)
      $display("[TB] FAIL basic_result: got notify=%b m_out=%0d busy=%b expected notify=1 m_out=10 busy=0", a_notify, a_m_out, a_busy);
    else checks_passed++;
    tick();
    checks_total++;
    if (a_notify !== 1'b0) $display("[TB] FAIL basic_notify_one_cycle: got %b expected 0", a_notify);
    else checks_passed++;
  endtask

  // Partial window 5,5 is discarded when en drops; the next 1,1,1,1 gives 4.
  task automatic test_discard();
    a_sync = 1'b1;
    a_en   = 1'b1;
    a_s_in = 32'd5;
    tick();
    tick();
    checks_total++;
    if (a_busy !== 1'b1) $display("[TB] FAIL discard_busy_partial: got %b expected 1", a_busy);
    else checks_passed++;
    a_en = 1'b0;
    tick();
    checks_total++;
    if (a_busy !== 1'b0 || a_notify !== 1'b0)
      $display("[TB] FAIL discard_cleared: got busy=%b notify=%b expected busy=0 notify=0", a_busy, a_notify);
    else checks_passed++;
    a_en   = 1'b1;
    a_s_in = 32'd1;
    repeat (4) tick();
    a_en = 1'b0;
    checks_total++;
    if (a_notify !== 1'b1 || a_m_out !== 32'd4)
      $display("[TB] FAIL discard_next_window: got notify=%b m_out=%0d expected notify=1 m_out=4", a_notify, a_m_out);
    else checks_passed++;
    tick();
    checks_total++;
    if (a_notify !== 1'b0 || a_drop !== 16'd0)
      $display("[TB] FAIL discard_drop: got notify=%b drop=%0d expected notify=0 drop=0", a_notify, a_drop);
    else checks_passed++;
  endtask

  // 0x7FFFFFFF + 1 + 0 + 0: wraps to 0x80000000, or saturates with the macro.
  task automatic test_overflow();
    logic [31:0] expected;
`ifdef MS_WINDOW_ACC_SATURATE_EN
    expected = 32'h7FFF_FFFF;
`else
    expected = 32'h8000_0000;
`endif
    a_sync = 1'b1;
    a_en   = 1'b1;
    a_s_in = 32'h7FFF_FFFF;
    tick();
    a_s_in = 32'd1;
    tick();
    a_s_in = 32'd0;
    tick();
    tick();
    a_en = 1'b0;
    checks_total++;
    if (a_notify !== 1'b1 || a_m_out !== expected)
      $display("[TB] FAIL overflow_result: got notify=%b m_out=%h expected notify=1 m_out=%h", a_notify, a_m_out, expected);
    else checks_passed++;
`ifdef MS_WINDOW_ACC_SATURATE_EN
    checks_total++;
    if (a_sat !== 1'b1) $display("[TB] FAIL overflow_sat_flag: got %b expected 1", a_sat);
    else checks_passed++;
`endif
    tick();
  endtask

  // WINDOW=1, DEPTH=4: six samples with no consumer keep 10..13, drop 2.
  task automatic test_drop_on_full();
    b_sync = 1'b0;
    b_en   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_s_in = 32'(10 + i);
      tick();
    end
    b_en = 1'b0;
    checks_total++;
    if (b_drop !== 16'd2 || b_m_out !== 32'd10)
      $display("[TB] FAIL drop_count: got drop=%0d head=%0d expected drop=2 head=10", b_drop, b_m_out);
    else checks_passed++;
    b_sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks_total++;
      if (b_notify !== 1'b1 || b_m_out !== 32'(10 + i))
        $display("[TB] FAIL drop_drain_%0d: got notify=%b m_out=%0d expected notify=1 m_out=%0d", i, b_notify, b_m_out, 10 + i);
      else checks_passed++;
      tick();
    end
    checks_total++;
    if (b_notify !== 1'b0 || b_m_out !== 32'd0 || b_drop !== 16'd2)
      $display("[TB] FAIL drop_empty: got notify=%b m_out=%0d drop=%0d expected notify=0 m_out=0 drop=2", b_notify, b_m_out, b_drop);
    else checks_passed++;
    b_sync = 1'b0;
  endtask

  // WINDOW=1, DEPTH=2 full FIFO with sync held: push and pop every cycle.
  task automatic test_back_to_back();
    c_sync = 1'b0;
    c_en   = 1'b1;
    c_s_in = 32'd100;
    tick();
    c_s_in = 32'd101;
    tick();
    c_sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c_s_in = 32'(102 + i);
      checks_total++;
      if (c_notify !== 1'b1 || c_m_out !== 32'(100 + i))
        $display("[TB] FAIL b2b_head_%0d: got notify=%b m_out=%0d expected notify=1 m_out=%0d", i, c_notify, c_m_out, 100 + i);
      else checks_passed++;
      tick();
    end
    c_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks_total++;
      if (c_m_out !== 32'(104 + i))
        $display("[TB] FAIL b2b_drain_%0d: got m_out=%0d expected %0d", i, c_m_out, 104 + i);
      else checks_passed++;
      tick();
    end
    checks_total++;
    if (c_notify !== 1'b0 || c_drop !== 16'd0)
      $display("[TB] FAIL b2b_end: got notify=%b drop=%0d expected notify=0 drop=0", c_notify, c_drop);
    else checks_passed++;
    c_sync = 1'b0;
  endtask

  // One result queued, two samples into the next window, then async reset.
  task automatic test_reset_mid_window();
    a_sync = 1'b0;
    a_en   = 1'b1;
    a_s_in = 32'd1;
    repeat (6) tick();
    checks_total++;
    if (a_notify !== 1'b1 || a_busy !== 1'b1)
      $display("[TB] FAIL midrst_setup: got notify=%b busy=%b expected notify=1 busy=1", a_notify, a_busy);
    else checks_passed++;
    a_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    checks_total++;
    if (a_notify !== 1'b0 || a_busy !== 1'b0 || a_drop !== 16'd0 || a_m_out !== 32'd0)
      $display("[TB] FAIL midrst_cleared: got notify=%b busy=%b drop=%0d m_out=%0d expected 0 0 0 0", a_notify, a_busy, a_drop, a_m_out);
    else checks_passed++;
    #1 rst = 1'b0;
    tick();
    a_sync = 1'b1;
    a_en   = 1'b1;
    a_s_in = 32'd1;
    repeat (4) tick();
    a_en = 1'b0;
    checks_total++;
    if (a_notify !== 1'b1 || a_m_out !== 32'd4)
      $display("[TB] FAIL midrst_next_window: got notify=%b m_out=%0d expected notify=1 m_out=4", a_notify, a_m_out);
    else checks_passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_discard();
    test_overflow();
    test_drop_on_full();
    test_back_to_back();
    test_reset_mid_window();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
